halfword_serializer: RTL

Single-clock word-to-halfword serializer: buffers 32-bit words in a small FIFO and emits each as two 16-bit halfwords, high first, then low. It is the transmit end of the halfword link whose receiver reassembles halfwords into 32-bit words in a 2-word mesochronous FIFO. Its halfword outputs connect directly to that receiver's halfword write port, and the receiver's `o_stall` drives this block's `i_stall`.

---
 rtl/halfword_serializer_pkg.sv | 25 ++
 rtl/halfword_serializer_fifo.sv | 64 ++++++
 rtl/halfword_serializer.sv | 66 ++++++
 3 files changed

// File: rtl/halfword_serializer_pkg.sv
// Shared constants, phase encoding and pointer-width helper for the halfword link transmitter.
`ifndef DH
`define DH
`endif

package halfword_serializer_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic {
    PHASE_HIGH = 1'b0,
    PHASE_LOW  = 1'b1
  } phase_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/halfword_serializer_fifo.sv
// Generic single-clock word FIFO with wrap-bit pointers; storage and full/empty flags only.
`ifndef DH
`define DH
`endif

module sync_word_fifo
  import halfword_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic             pushEn, popEn;

  // Same slot with opposite wrap bits means the writer has lapped the reader.
  assign full_o  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign empty_o = (head_q == tail_q);
  assign pushEn  = push_i & ~full_o;
  assign popEn   = pop_i & ~empty_o;
  assign rdata_o = mem_q[tail_q[AW-1:0]];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pushEn) begin
      head_d = head_q + PW'(1);
    end
    if (popEn) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= `DH '0;
      tail_q <= `DH '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= `DH '0;
      end
    end else begin
      head_q <= `DH head_d;
      tail_q <= `DH tail_d;
      if (pushEn) begin
        mem_q[head_q[AW-1:0]] <= `DH wdata_i;
      end
    end
  end

endmodule

// File: rtl/halfword_serializer.sv
// Word-to-halfword serializer: buffers 32-bit words and emits each as high then low halfword.
`ifndef DH
`define DH
`endif

module halfword_serializer
  import halfword_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_stall,
  output logic [HALF_W-1:0] o_data,
  output logic              o_valid_high,
  output logic              o_valid_low,
  input  logic              i_stall
);

  phase_e            phase_q, phase_d;
  logic [WORD_W-1:0] headWord;
  logic              fifoFull, fifoEmpty;
  logic              push, popHalf, popWord;

  assign push    = i_valid & ~fifoFull;
  assign popHalf = (o_valid_high | o_valid_low) & ~i_stall;
  assign popWord = popHalf & (phase_q == PHASE_LOW);

  sync_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (i_data),
    .pop_i   (popWord),
    .rdata_o (headWord),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_comb begin
    phase_d = phase_q;
    if (popHalf) begin
      phase_d = (phase_q == PHASE_HIGH) ? PHASE_LOW : PHASE_HIGH;
    end
  end

  // Phase is cleared on reset so a half-sent word never leaves a stale low half pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= `DH PHASE_HIGH;
    end else begin
      phase_q <= `DH phase_d;
    end
  end

  assign o_stall      = fifoFull;
  assign o_valid_high = ~fifoEmpty & (phase_q == PHASE_HIGH);
  assign o_valid_low  = ~fifoEmpty & (phase_q == PHASE_LOW);
  assign o_data       = (phase_q == PHASE_LOW) ? headWord[HALF_W-1:0] : headWord[WORD_W-1:HALF_W];

endmodule
